// File: rtl/slurm16_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : slurm16_regfile_pkg
//  Purpose  : Shared register file constants, well-known register indices
//             and scrub state encoding for the slurm16 CPU.
//  Revision : 1.0 - initial release
// ============================================================================
package slurm16_regfile_pkg;

    localparam int REGISTER_BITS = 7;
    localparam int BITS          = 16;
    localparam int ZERO_REG      = 0;

    // Link registers written by call / interrupt entry in writeback
    localparam int LINK_REGISTER           = 15;
    localparam int INTERRUPT_LINK_REGISTER = 14;

    typedef enum logic [0:0] {
        SCRUB = 1'b0,
        READY = 1'b1
    } scrub_state_t;

endpackage
`default_nettype wire

// File: rtl/slurm16_regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : slurm16_regfile_read_port
//  Purpose  : One registered register file read port: zero register,
//             same-cycle write bypass and operand hold under stall.
//  Revision : 1.0 - initial release
// ============================================================================
module slurm16_regfile_read_port #(
    parameter int REGISTER_BITS = slurm16_regfile_pkg::REGISTER_BITS,
    parameter int BITS          = slurm16_regfile_pkg::BITS,
    parameter int ZERO_REG      = slurm16_regfile_pkg::ZERO_REG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_stall,
    input  logic                     i_force_zero,
    input  logic [REGISTER_BITS-1:0] i_sel,
    input  logic                     i_wr_en,
    input  logic [REGISTER_BITS-1:0] i_wr_sel,
    input  logic [BITS-1:0]          i_wr_data,
    input  logic [BITS-1:0]          i_mem_data,
    output logic [BITS-1:0]          o_data
);
    import slurm16_regfile_pkg::*;

    localparam logic [REGISTER_BITS-1:0] c_zero_sel = REGISTER_BITS'(ZERO_REG);

    logic [REGISTER_BITS-1:0] r_held_sel;
    logic [BITS-1:0]          r_data;
    logic [BITS-1:0]          w_data_next;

    // Select the next operand: zero / bypass / array when running, refresh-or-hold when stalled
    always_comb begin
        w_data_next = r_data;
        if (!i_stall) begin
            if (i_force_zero || (i_sel == c_zero_sel)) begin
                w_data_next = '0;
            end else if (i_wr_en && (i_wr_sel == i_sel)) begin
                w_data_next = i_wr_data;
            end else begin
                w_data_next = i_mem_data;
            end
        end else if (i_wr_en && (r_held_sel != c_zero_sel) && (i_wr_sel == r_held_sel)) begin
            // A write landing on the held register keeps the stalled operand fresh
            w_data_next = i_wr_data;
        end
    end

    // Held select and output register; the select only advances when not stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held_sel <= '0;
            r_data     <= '0;
        end else begin
            if (!i_stall) begin
                r_held_sel <= i_sel;
            end
            r_data <= w_data_next;
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/slurm16_cpu_registers.sv
`default_nettype none
// ============================================================================
//  Module   : slurm16_cpu_registers
//  Purpose  : slurm16 register file - one write port from writeback, two
//             registered read ports (A, B) for decode/execute.
//  Options  : SLURM16_REGFILE_SCRUB_EN - zero the array after every reset;
//             busy is high while the scrub runs.
//  Revision : 1.0 - initial release
// ============================================================================
module slurm16_cpu_registers #(
    parameter int REGISTER_BITS = slurm16_regfile_pkg::REGISTER_BITS,
    parameter int BITS          = slurm16_regfile_pkg::BITS,
    parameter int ZERO_REG      = slurm16_regfile_pkg::ZERO_REG
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [REGISTER_BITS-1:0] regA_sel,
    input  logic [REGISTER_BITS-1:0] regB_sel,
    input  logic                     stall,
    input  logic [REGISTER_BITS-1:0] reg_wr_sel,
    input  logic [BITS-1:0]          reg_in,
    output logic [BITS-1:0]          regA_out,
    output logic [BITS-1:0]          regB_out,
    output logic                     busy
);
    import slurm16_regfile_pkg::*;

    localparam int                       c_depth    = 2 ** REGISTER_BITS;
    localparam logic [REGISTER_BITS-1:0] c_zero_sel = REGISTER_BITS'(ZERO_REG);

    // Array carries no reset so it maps onto RAM
    logic [BITS-1:0]          r_mem [c_depth];

    logic                     w_busy;
    logic                     w_ext_we;
    logic                     w_mem_we;
    logic [REGISTER_BITS-1:0] w_mem_addr;
    logic [BITS-1:0]          w_mem_wdata;

    // Writeback writes are ignored for the zero register and while scrubbing
    assign w_ext_we = (reg_wr_sel != c_zero_sel) && !w_busy;

`ifdef SLURM16_REGFILE_SCRUB_EN
    scrub_state_t             r_scrub_state;
    scrub_state_t             w_scrub_state_next;
    logic [REGISTER_BITS-1:0] r_scrub_cnt;
    logic [REGISTER_BITS-1:0] w_scrub_cnt_next;

    // Scrub state and index register; reset restarts the sweep at index 1
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_scrub_state <= SCRUB;
            r_scrub_cnt   <= REGISTER_BITS'(1);
        end else begin
            r_scrub_state <= w_scrub_state_next;
            r_scrub_cnt   <= w_scrub_cnt_next;
        end
    end

    // Sweep indices 1..top once, then stay READY until the next reset
    always_comb begin
        w_scrub_state_next = r_scrub_state;
        w_scrub_cnt_next   = r_scrub_cnt;
        if (r_scrub_state == SCRUB) begin
            w_scrub_cnt_next = r_scrub_cnt + 1'b1;
            if (&r_scrub_cnt) begin
                w_scrub_state_next = READY;
            end
        end
    end

    assign w_busy = (r_scrub_state == SCRUB);

    // Array write mux: the scrub owns the write port while it runs
    always_comb begin
        w_mem_we    = w_ext_we;
        w_mem_addr  = reg_wr_sel;
        w_mem_wdata = reg_in;
        if (w_busy) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_scrub_cnt;
            w_mem_wdata = '0;
        end
    end
`else
    assign w_busy = 1'b0;

    // Array write mux: writeback is the only writer
    always_comb begin
        w_mem_we    = w_ext_we;
        w_mem_addr  = reg_wr_sel;
        w_mem_wdata = reg_in;
    end
`endif

    // Array write port
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    slurm16_regfile_read_port #(
        .REGISTER_BITS (REGISTER_BITS),
        .BITS          (BITS),
        .ZERO_REG      (ZERO_REG)
    ) u_port_a (
        .clk          (CLK),
        .rst          (RST),
        .i_stall      (stall),
        .i_force_zero (w_busy),
        .i_sel        (regA_sel),
        .i_wr_en      (w_ext_we),
        .i_wr_sel     (reg_wr_sel),
        .i_wr_data    (reg_in),
        .i_mem_data   (r_mem[regA_sel]),
        .o_data       (regA_out)
    );

    slurm16_regfile_read_port #(
        .REGISTER_BITS (REGISTER_BITS),
        .BITS          (BITS),
        .ZERO_REG      (ZERO_REG)
    ) u_port_b (
        .clk          (CLK),
        .rst          (RST),
        .i_stall      (stall),
        .i_force_zero (w_busy),
        .i_sel        (regB_sel),
        .i_wr_en      (w_ext_we),
        .i_wr_sel     (reg_wr_sel),
        .i_wr_data    (reg_in),
        .i_mem_data   (r_mem[regB_sel]),
        .o_data       (regB_out)
    );

    assign busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_slurm16_cpu_registers.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slurm16_cpu_registers
//  Purpose  : Scoreboard testbench for slurm16_cpu_registers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slurm16_cpu_registers;

    logic        CLK;
    logic        RST;
    logic [6:0]  regA_sel;
    logic [6:0]  regB_sel;
    logic        stall;
    logic [6:0]  reg_wr_sel;
    logic [15:0] reg_in;
    logic [15:0] regA_out;
    logic [15:0] regB_out;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        string       name;
        int          port;   // 0 = A, 1 = B
        logic [15:0] exp;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    slurm16_cpu_registers u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .regA_sel   (regA_sel),
        .regB_sel   (regB_sel),
        .stall      (stall),
        .reg_wr_sel (reg_wr_sel),
        .reg_in     (reg_in),
        .regA_out   (regA_out),
        .regB_out   (regB_out),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: retire every expectation whose edge has passed
    always @(negedge CLK) begin
        exp_t        t;
        logic [15:0] act;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            t   = sb_q.pop_front();
            act = (t.port == 0) ? regA_out : regB_out;
            chk(t.name, act, t.exp);
        end
    end

    task automatic expect_out(input string name, input int port, input logic [15:0] e);
        exp_t t;
        t.name = name;
        t.port = port;
        t.exp  = e;
        t.due  = cyc + 1;
        sb_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [6:0] a, input logic [6:0] b, input logic [6:0] w,
                         input logic [15:0] d, input logic s);
        regA_sel   = a;
        regB_sel   = b;
        reg_wr_sel = w;
        reg_in     = d;
        stall      = s;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        if (busy) chk("busy_timeout", 16'(busy), 16'h0000);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 300) begin
            drive(7'd100, 7'd0, (n == 10) ? 7'd1 : 7'd0, 16'h1234, 1'b0);
            if (n == 20) expect_out("a_zero_during_scrub", 0, 16'h0000);
            tick();
            n++;
        end
    endtask

    initial begin
        int nb;
        RST = 1'b1;
        drive(7'd0, 7'd0, 7'd0, 16'h0000, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_a", regA_out, 16'h0000);
        chk("reset_b", regB_out, 16'h0000);
        RST = 1'b0;
`ifdef SLURM16_REGFILE_SCRUB_EN
        chk("busy_after_reset", 16'(busy), 16'h0001);
        wait_ready();
`else
        chk("busy_tied_low", 16'(busy), 16'h0000);
`endif

        drive(7'd0, 7'd0, 7'd5, 16'h1234, 1'b0);
        expect_out("a_zero_sel", 0, 16'h0000);
        tick();
        drive(7'd5, 7'd0, 7'd7, 16'h7777, 1'b0);
        expect_out("a_r5", 0, 16'h1234);
        expect_out("b_zero_sel", 1, 16'h0000);
        tick();
        drive(7'd5, 7'd9, 7'd9, 16'hBEEF, 1'b0);
        expect_out("b_bypass", 1, 16'hBEEF);
        expect_out("a_r5_again", 0, 16'h1234);
        tick();
        drive(7'd0, 7'd9, 7'd0, 16'hFFFF, 1'b0);
        expect_out("b_array_after_bypass", 1, 16'hBEEF);
        tick();
        drive(7'd0, 7'd0, 7'd0, 16'hFFFF, 1'b0);
        expect_out("a_r0_write_ignored", 0, 16'h0000);
        expect_out("b_r0_write_ignored", 1, 16'h0000);
        tick();
        drive(7'd3, 7'd3, 7'd3, 16'h1111, 1'b0);
        expect_out("a_same_reg_bypass", 0, 16'h1111);
        expect_out("b_same_reg_bypass", 1, 16'h1111);
        tick();
        drive(7'd3, 7'd3, 7'd0, 16'h0000, 1'b0);
        expect_out("a_r3", 0, 16'h1111);
        tick();

        // Stall for three cycles while the selects move to r7
        drive(7'd7, 7'd7, 7'd0, 16'h0000, 1'b1);
        expect_out("a_stall_hold", 0, 16'h1111);
        tick();
        drive(7'd7, 7'd7, 7'd3, 16'h2222, 1'b1);
        expect_out("a_stall_wr_held", 0, 16'h2222);
        expect_out("b_stall_wr_held", 1, 16'h2222);
        tick();
        drive(7'd7, 7'd7, 7'd12, 16'h5555, 1'b1);
        expect_out("a_stall_other_wr", 0, 16'h2222);
        tick();
        drive(7'd7, 7'd12, 7'd0, 16'h0000, 1'b0);
        expect_out("a_after_stall_r7", 0, 16'h7777);
        expect_out("b_r12_written_in_stall", 1, 16'h5555);
        tick();

        // Asynchronous reset between edges, mid-stall
        drive(7'd7, 7'd12, 7'd0, 16'h0000, 1'b1);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_a", regA_out, 16'h0000);
        chk("async_rst_b", regB_out, 16'h0000);
        tick();
        drive(7'd9, 7'd3, 7'd0, 16'h0000, 1'b0);
        RST = 1'b0;
`ifdef SLURM16_REGFILE_SCRUB_EN
        wait_ready();
        expect_out("a_post_reset_r9", 0, 16'h0000);
        expect_out("b_post_reset_r3", 1, 16'h0000);
`else
        expect_out("a_post_reset_r9", 0, 16'hBEEF);
        expect_out("b_post_reset_r3", 1, 16'h2222);
`endif
        tick();

`ifdef SLURM16_REGFILE_SCRUB_EN
        drive(7'd0, 7'd0, 7'd100, 16'hAAAA, 1'b0);
        tick();
        drive(7'd100, 7'd0, 7'd0, 16'h0000, 1'b0);
        expect_out("r100_preload", 0, 16'hAAAA);
        tick();
        @(negedge CLK);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        count_busy(nb);
        chk("busy_cycles", 16'(nb), 16'd127);
        drive(7'd100, 7'd127, 7'd0, 16'h0000, 1'b0);
        expect_out("r100_scrubbed", 0, 16'h0000);
        expect_out("r127_scrubbed", 1, 16'h0000);
        tick();
        drive(7'd1, 7'd0, 7'd0, 16'h0000, 1'b0);
        expect_out("r1_write_dropped", 0, 16'h0000);
        tick();

        // Restart the scrub partway through
        @(negedge CLK);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (50) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        count_busy(nb);
        chk("busy_cycles_restart", 16'(nb), 16'd127);
`endif

        drive(7'd0, 7'd0, 7'd0, 16'h0000, 1'b0);
        repeat (3) @(negedge CLK);
        if (sb_q.size() != 0) chk("scoreboard_drain", 16'(sb_q.size()), 16'h0000);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
